// File: rtl/red_pitaya_fads_pkg.sv
// FADS sorting sequencer: shared states, register map and defaults.
package red_pitaya_fads_pkg;

  localparam int CW_DEF  = 16;
  localparam int DLW_DEF = 24;
  localparam int SCW_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MEAS  = 2'd1,
    S_DELAY = 2'd2,
    S_FIRE  = 2'd3
  } state_t;

  localparam logic [19:0] A_CTRL   = 20'h00;
  localparam logic [19:0] A_MIN_W  = 20'h04;
  localparam logic [19:0] A_MAX_W  = 20'h08;
  localparam logic [19:0] A_DELAY  = 20'h0C;
  localparam logic [19:0] A_PULSE  = 20'h10;
  localparam logic [19:0] A_STATUS = 20'h14;
  localparam logic [19:0] A_DROP   = 20'h18;
  localparam logic [19:0] A_SORT   = 20'h1C;
  localparam logic [19:0] A_MISS   = 20'h20;

  localparam logic [31:0] MIN_W_RST = 32'd1;
  localparam logic [31:0] MAX_W_RST = 32'hFFFF;
  localparam logic [31:0] DELAY_RST = 32'd0;
  localparam logic [31:0] PULSE_RST = 32'd1;

endpackage

// File: rtl/red_pitaya_fads_satcnt.sv
// Saturating event counter; clear beats increment.
module red_pitaya_fads_satcnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/red_pitaya_fads_sequencer.sv
// FADS sorting sequencer: droplet width gate, flight delay,
// trigger pulse to the ASG, bus registers and statistics.
module red_pitaya_fads_sequencer
  import red_pitaya_fads_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int DLW = DLW_DEF,
  parameter int SCW = SCW_DEF
) (
  input  logic        adc_clk_i,
  input  logic        adc_rst_i,
  input  logic        drop_i,
  input  logic        hit_i,
  output logic        asg_trig_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  logic           enable;
  logic [CW-1:0]  min_w;
  logic [CW-1:0]  max_w;
  logic [DLW-1:0] delay;
  logic [CW-1:0]  pulse;

  state_t         state;
  state_t         state_n;
  logic           drop_q;
  logic           rise;
  logic           fall;
  logic           hit_seen;
  logic [CW-1:0]  width;
  logic [DLW-1:0] dcnt;
  logic [CW-1:0]  pcnt;

  logic           start;
  logic           accept;
  logic           width_ok;
  logic           inc_drop;
  logic           inc_sort;
  logic           inc_miss;
  logic           clr;

  logic [SCW-1:0] drop_cnt;
  logic [SCW-1:0] sort_cnt;
  logic [SCW-1:0] miss_cnt;

  logic [19:0]    addr;
  logic [31:0]    rd_mux;
  logic           unused;

  assign addr   = sys_addr[19:0];
  assign unused = ^{sys_addr[31:20], sys_sel, sys_wdata};
  assign rise   = drop_i & ~drop_q;
  assign fall   = ~drop_i & drop_q;
  assign clr    = sys_wen && (addr == A_CTRL)
                  && sys_wdata[1];

  assign width_ok = hit_seen
                    && (width >= min_w)
                    && (width <= max_w);

  always_comb begin
    state_n  = state;
    start    = 1'b0;
    accept   = 1'b0;
    inc_drop = 1'b0;
    inc_sort = 1'b0;
    inc_miss = 1'b0;
    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            state_n = S_MEAS;
            start   = 1'b1;
          end
        end
        S_MEAS: begin
          if (fall) begin
            inc_drop = 1'b1;
            if (width_ok) begin
              accept   = 1'b1;
              inc_sort = 1'b1;
              state_n  = (delay == '0) ? S_FIRE
                                       : S_DELAY;
            end else begin
              state_n = S_IDLE;
            end
          end
        end
        S_DELAY: begin
          inc_drop = rise;
          inc_miss = rise;
          if (dcnt <= DLW'(1))
            state_n = S_FIRE;
        end
        S_FIRE: begin
          inc_drop = rise;
          inc_miss = rise;
          if (pcnt <= CW'(1))
            state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state      <= S_IDLE;
      drop_q     <= 1'b0;
      hit_seen   <= 1'b0;
      width      <= '0;
      dcnt       <= '0;
      pcnt       <= '0;
      asg_trig_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      drop_q     <= drop_i;
      asg_trig_o <= (state_n == S_FIRE);
      busy_o     <= (state_n == S_DELAY)
                    || (state_n == S_FIRE);
      if (start) begin
        width    <= CW'(1);
        hit_seen <= hit_i;
      end else if (state == S_MEAS) begin
        hit_seen <= hit_seen | hit_i;
        if (drop_i && (width != '1))
          width <= width + 1'b1;
      end
      // event timing is frozen here; later writes wait
      if (accept) begin
        dcnt <= delay;
        pcnt <= (pulse == '0) ? CW'(1) : pulse;
      end else if (state == S_DELAY) begin
        dcnt <= dcnt - 1'b1;
      end else if (state == S_FIRE) begin
        pcnt <= pcnt - 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      enable    <= 1'b0;
      min_w     <= MIN_W_RST[CW-1:0];
      max_w     <= MAX_W_RST[CW-1:0];
      delay     <= DELAY_RST[DLW-1:0];
      pulse     <= PULSE_RST[CW-1:0];
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_wen) begin
        case (addr)
          A_CTRL:  enable <= sys_wdata[0];
          A_MIN_W: min_w  <= sys_wdata[CW-1:0];
          A_MAX_W: max_w  <= sys_wdata[CW-1:0];
          A_DELAY: delay  <= sys_wdata[DLW-1:0];
          A_PULSE: pulse  <= sys_wdata[CW-1:0];
          default: ;
        endcase
      end
      if (sys_ren)
        sys_rdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:   rd_mux = {31'd0, enable};
      A_MIN_W:  rd_mux = 32'(min_w);
      A_MAX_W:  rd_mux = 32'(max_w);
      A_DELAY:  rd_mux = 32'(delay);
      A_PULSE:  rd_mux = 32'(pulse);
      A_STATUS: rd_mux = {30'd0, state};
      A_DROP:   rd_mux = 32'(drop_cnt);
      A_SORT:   rd_mux = 32'(sort_cnt);
      A_MISS:   rd_mux = 32'(miss_cnt);
      default:  rd_mux = '0;
    endcase
  end

  assign sys_err = 1'b0;

  red_pitaya_fads_satcnt #(.W(SCW)) u_drop (
    .clk (adc_clk_i),
    .rst (adc_rst_i),
    .clr (clr),
    .inc (inc_drop),
    .cnt (drop_cnt)
  );

  red_pitaya_fads_satcnt #(.W(SCW)) u_sort (
    .clk (adc_clk_i),
    .rst (adc_rst_i),
    .clr (clr),
    .inc (inc_sort),
    .cnt (sort_cnt)
  );

  red_pitaya_fads_satcnt #(.W(SCW)) u_miss (
    .clk (adc_clk_i),
    .rst (adc_rst_i),
    .clr (clr),
    .inc (inc_miss),
    .cnt (miss_cnt)
  );

endmodule

// File: tb/tb_red_pitaya_fads_sequencer.sv
// Directed bench for the FADS sorting sequencer.
module tb_red_pitaya_fads_sequencer;

  logic        clk;
  logic        rst;
  logic        drop_i;
  logic        hit_i;
  logic        asg_trig_o;
  logic        busy_o;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  int n_chk;
  int n_fail;
  int cyc;
  int trig_n;
  int trig_first;
  int fall_cyc;

  red_pitaya_fads_sequencer dut (
    .adc_clk_i  (clk),
    .adc_rst_i  (rst),
    .drop_i     (drop_i),
    .hit_i      (hit_i),
    .asg_trig_o (asg_trig_o),
    .busy_o     (busy_o),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_sel    (sys_sel),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // one clock; sample trigger away from the active edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (asg_trig_o === 1'b1) begin
      if (trig_n == 0) trig_first = cyc;
      trig_n++;
    end
  endtask

  task automatic bus_wr(input logic [31:0] a,
                        input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    tick();
    sys_wen   = 1'b0;
  endtask

  task automatic bus_rd(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    sys_addr = a;
    sys_ren  = 1'b1;
    tick();
    sys_ren  = 1'b0;
    check({tag, "_ack"}, {31'd0, sys_ack}, 32'd1);
    check(tag, sys_rdata, exp);
  endtask

  task automatic cfg(input int mn, input int mx,
                     input int d, input int p);
    bus_wr(32'h04, mn);
    bus_wr(32'h08, mx);
    bus_wr(32'h0C, d);
    bus_wr(32'h10, p);
    bus_wr(32'h00, 32'd1);
  endtask

  // w cycles high, hit on cycle index hit_at (-1: none)
  task automatic drop(input int w, input int hit_at);
    drop_i = 1'b1;
    hit_i  = (hit_at == 0);
    for (int i = 1; i < w; i++) begin
      tick();
      hit_i = (hit_at == i);
    end
    tick();
    drop_i   = 1'b0;
    hit_i    = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic rd_defaults(input string tag);
    bus_rd({tag, "_ctrl"},   32'h00, 32'd0);
    bus_rd({tag, "_minw"},   32'h04, 32'd1);
    bus_rd({tag, "_maxw"},   32'h08, 32'hFFFF);
    bus_rd({tag, "_delay"},  32'h0C, 32'd0);
    bus_rd({tag, "_pulse"},  32'h10, 32'd1);
    bus_rd({tag, "_status"}, 32'h14, 32'd0);
    bus_rd({tag, "_dropc"},  32'h18, 32'd0);
    bus_rd({tag, "_sortc"},  32'h1C, 32'd0);
    bus_rd({tag, "_missc"},  32'h20, 32'd0);
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    cyc        = 0;
    trig_n     = 0;
    trig_first = 0;
    fall_cyc   = 0;
    rst        = 1'b1;
    drop_i     = 1'b0;
    hit_i      = 1'b0;
    sys_addr   = '0;
    sys_wdata  = '0;
    sys_sel    = 4'hF;
    sys_wen    = 1'b0;
    sys_ren    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_trig", {31'd0, asg_trig_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ack",  {31'd0, sys_ack}, 32'd0);
    check("rst_err",  {31'd0, sys_err}, 32'd0);
    rd_defaults("rst");

    // sorted droplet, width 6, delay 5, pulse 3
    cfg(4, 10, 5, 3);
    bus_wr(32'h00, 32'd3);
    trig_n = 0;
    drop(6, 2);
    tick();
    check("t1_busy", {31'd0, busy_o}, 32'd1);
    repeat (15) tick();
    check("t1_lat", 32'(trig_first - fall_cyc), 32'd5);
    check("t1_len", 32'(trig_n), 32'd3);
    check("t1_idle", {31'd0, busy_o}, 32'd0);
    bus_rd("t1_dropc", 32'h18, 32'd1);
    bus_rd("t1_sortc", 32'h1C, 32'd1);

    // rejects: too narrow, too wide, no hit
    bus_wr(32'h00, 32'd3);
    trig_n = 0;
    drop(3, 1);
    repeat (3) tick();
    drop(11, 1);
    repeat (3) tick();
    drop(6, -1);
    repeat (15) tick();
    check("t2_len", 32'(trig_n), 32'd0);
    bus_rd("t2_dropc", 32'h18, 32'd3);
    bus_rd("t2_sortc", 32'h1C, 32'd0);
    bus_rd("t2_missc", 32'h20, 32'd0);

    // width exactly MIN_W and MAX_W are sorted
    trig_n = 0;
    drop(4, 0);
    repeat (12) tick();
    drop(10, 9);
    repeat (15) tick();
    check("t2b_len", 32'(trig_n), 32'd6);
    bus_rd("t2b_sortc", 32'h1C, 32'd2);

    // zero delay, zero pulse length
    cfg(4, 10, 0, 0);
    trig_n = 0;
    drop(6, 1);
    repeat (6) tick();
    check("t3_lat", 32'(trig_first - fall_cyc), 32'd0);
    check("t3_len", 32'(trig_n), 32'd1);

    // rises during DELAY and on last FIRE cycle
    cfg(4, 10, 5, 3);
    bus_wr(32'h00, 32'd3);
    trig_n = 0;
    drop(6, 1);
    tick();
    drop_i = 1'b1;
    tick();
    drop_i = 1'b0;
    repeat (6) tick();
    drop_i = 1'b1;
    tick();
    drop_i = 1'b0;
    repeat (10) tick();
    check("t4_len", 32'(trig_n), 32'd3);
    check("t4_lat", 32'(trig_first - fall_cyc), 32'd5);
    bus_rd("t4_missc", 32'h20, 32'd2);
    bus_rd("t4_dropc", 32'h18, 32'd3);
    bus_rd("t4_sortc", 32'h1C, 32'd1);

    // rise in first IDLE cycle after FIRE is measured
    bus_wr(32'h00, 32'd3);
    trig_n = 0;
    drop(6, 1);
    repeat (9) tick();
    drop(6, 1);
    repeat (15) tick();
    check("t4b_len", 32'(trig_n), 32'd6);
    bus_rd("t4b_sortc", 32'h1C, 32'd2);
    bus_rd("t4b_missc", 32'h20, 32'd0);

    // disable mid-delay
    bus_wr(32'h00, 32'd3);
    trig_n = 0;
    drop(6, 1);
    repeat (3) tick();
    bus_wr(32'h00, 32'd0);
    tick();
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    repeat (10) tick();
    check("t5_len", 32'(trig_n), 32'd0);
    bus_rd("t5_status", 32'h14, 32'd0);
    bus_rd("t5_dropc", 32'h18, 32'd1);
    bus_rd("t5_sortc", 32'h1C, 32'd1);

    // clr coincident with the fall
    bus_wr(32'h00, 32'd1);
    drop(6, 1);
    bus_wr(32'h00, 32'd3);
    repeat (12) tick();
    bus_rd("t6_dropc", 32'h18, 32'd0);
    bus_rd("t6_sortc", 32'h1C, 32'd0);
    bus_rd("t6_missc", 32'h20, 32'd0);
    bus_rd("t6_ctrl",  32'h00, 32'd1);

    // register readback
    bus_wr(32'h04, 32'd7);
    bus_wr(32'h08, 32'h33);
    bus_wr(32'h0C, 32'hFF12_3456);
    bus_wr(32'h10, 32'd9);
    bus_rd("t7_ctrl",   32'h00, 32'd1);
    bus_rd("t7_minw",   32'h04, 32'd7);
    bus_rd("t7_maxw",   32'h08, 32'h33);
    bus_rd("t7_delay",  32'h0C, 32'h12_3456);
    bus_rd("t7_pulse",  32'h10, 32'd9);
    bus_rd("t7_status", 32'h14, 32'd0);
    bus_rd("t7_unmap",  32'h24, 32'd0);

    // reset during FIRE
    cfg(4, 10, 2, 5);
    drop(6, 1);
    repeat (4) tick();
    check("t8_fire", {31'd0, asg_trig_o}, 32'd1);
    rst = 1'b1;
    tick();
    check("t8_trig", {31'd0, asg_trig_o}, 32'd0);
    check("t8_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;
    tick();
    rd_defaults("t8");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_fads_sequencer.md
# red_pitaya_fads_sequencer

Sorting sequencer for the FADS path. It takes the per-sample comparator flags produced by the fluorescence detector and measures each droplet's width. It decides whether the droplet is sorted, waits a programmable flight delay, then fires a fixed-length trigger pulse to the ASG driving the high-voltage amplifier. Configuration and event statistics sit on the system bus alongside the detector registers.

## Interface
- `CW`, 16: width / pulse-length counter width
- `DLW`, 24: flight-delay counter width
- `SCW`, 32: statistics counter width
- `adc_clk_i` in 1: ADC clock; the only clock
- `adc_rst_i` in 1: reset, synchronous, active-high
- `drop_i` in 1: signal above detection threshold (droplet present)
- `hit_i` in 1: signal inside sort window (detector window flag)
- `asg_trig_o` out 1: ASG sort trigger pulse
- `busy_o` out 1: high in DELAY or FIRE
- `sys_addr` in 32, `sys_wdata` in 32, `sys_sel` in 4, `sys_wen` in 1, `sys_ren` in 1: system bus request
- `sys_rdata` out 32, `sys_err` out 1, `sys_ack` out 1: system bus response

## Operation
- Decoding uses `sys_addr[19:0]`. `sys_ack` follows `sys_wen|sys_ren` one cycle later; `sys_err` is always 0. Unmapped reads return 0.
- Register map:
  - 0x00 CTRL: bit0 `enable` (reset 0); bit1 `clr` is write-1, self-clearing, and zeroes all statistics counters.
  - 0x04 MIN_W (reset 1).
  - 0x08 MAX_W (reset 0xFFFF).
  - 0x0C DELAY (reset 0).
  - 0x10 PULSE (reset 1; a written 0 acts as 1).
  - 0x14 STATUS (RO): [1:0] state.
  - 0x18 DROP_CNT, 0x1C SORT_CNT, 0x20 MISS_CNT (RO).
- `drop_i` is registered once as `drop_q`.
  - Rise: `drop_i & ~drop_q`.
  - Fall: the first cycle with `~drop_i & drop_q`.
- FSM states: IDLE=0, MEAS=1, DELAY=2, FIRE=3.
  - IDLE → MEAS on rise while `enable`. Width counter loads 1 and `hit_seen` loads `hit_i`.
  - MEAS: width increments each cycle `drop_i`=1, saturating at 2^CW−1. `hit_seen |= hit_i`.
  - MEAS on fall: DROP_CNT increments. If `hit_seen` and MIN_W ≤ width ≤ MAX_W, go to DELAY: SORT_CNT increments, DELAY and PULSE are latched, and the delay counter loads the latched DELAY. Otherwise return to IDLE.
  - DELAY: count down. Go to FIRE in the cycle the counter reaches 0, so DELAY=0 means FIRE starts the cycle after the fall.
  - FIRE: `asg_trig_o`=1 for exactly the latched PULSE cycles, then IDLE.
- A rise during DELAY or FIRE is not measured. DROP_CNT and MISS_CNT each increment once per rise.
- A rise while `enable`=0 is ignored entirely (no counters).
- Clearing `enable` in any state: next cycle state=IDLE and `asg_trig_o`=0; counters hold.
- Register writes during DELAY/FIRE do not affect the event in flight.
- Statistics counters saturate at 2^SCW−1. A `clr` in the same cycle as an increment wins (result 0).

## Timing
- Reset: state IDLE, `asg_trig_o`=0, `busy_o`=0, `sys_ack`=0, `sys_err`=0, all counters 0, registers at the reset values above.
- Latency: with fall sampled at cycle F, `asg_trig_o` rises at F+1+DELAY and is high for cycles F+1+DELAY … F+DELAY+PULSE.
- `asg_trig_o` and `busy_o` are registered outputs.
- A rise coincident with the last FIRE cycle is a miss. A rise in the first IDLE cycle after FIRE is measured.
- Reset asserted mid-operation aborts everything in one cycle; there is no partial pulse after reset.

## Structure
- Package `red_pitaya_fads_pkg` holds:
  - the state enum
  - register offset constants
  - reset-default constants
  - CW/DLW/SCW defaults
- Sub-module `red_pitaya_fads_satcnt` is a parameterised saturating counter with `clr`/`inc` and clear priority. It is instantiated for DROP_CNT, SORT_CNT and MISS_CNT.
- FSM, timers and the bus register file stay in the top module.

## Test plan
- `enable`=1, MIN_W=4, MAX_W=10, DELAY=5, PULSE=3; `drop_i` high 6 cycles with `hit_i` high in cycle 3 → `asg_trig_o` high at F+6..F+8; DROP_CNT=1, SORT_CNT=1.
- Same config; widths 3 and 11 with hit, and width 6 without hit → no pulse; DROP_CNT=3, SORT_CNT=0.
- DELAY=0, PULSE=0 → one-cycle pulse at F+1.
- A second droplet rising during DELAY, and a third during FIRE → only the first pulse fires; MISS_CNT=2, DROP_CNT=3.
- Clear `enable` at delay midpoint → no pulse and state reads 0. Write `clr` in the same cycle as a fall → all counters read 0.
- Bus writes to 0x04..0x10 and reads of 0x00..0x20 and 0x24 → `sys_ack` one cycle after request; readback matches, with 0 for 0x24. Assert `adc_rst_i` during FIRE → `asg_trig_o`=0 next cycle and all registers return to defaults.
